// File: rtl/cv32e40p_cluster_clock_ctrl_if.sv
// Core-facing sleep/clock-gating signals between the CV32E40P core side
// (master) and the cluster clock controller (slave).
interface cv32e40p_cluster_clock_ctrl_if;
  logic core_sleep_i;     // core sleep indication
  logic bus_idle_i;       // no instr/data response pending toward the core
  logic pulp_clock_en_o;  // clock enable back to the core
  logic irq_o;            // interrupt to the core, released only in RUN
  logic debug_req_o;      // debug request to the core, released only in RUN
  logic bus_block_o;      // interconnect holds off grants/responses

  modport master (
    output core_sleep_i, bus_idle_i,
    input  pulp_clock_en_o, irq_o, debug_req_o, bus_block_o
  );

  modport slave (
    input  core_sleep_i, bus_idle_i,
    output pulp_clock_en_o, irq_o, debug_req_o, bus_block_o
  );
endinterface

// File: rtl/cv32e40p_cluster_clock_ctrl.sv
// Cluster-side clock gating controller for CV32E40P (COREV_CLUSTER = 1).
// Gates the core clock while it sleeps, holds off irq/debug/bus traffic
// until the clock has been running for WAKE_DELAY cycles, and latches
// cluster events that wake the core for a pending cv.elw.
// Optional feature: define CV32E40P_SLEEP_CNT_EN to build the saturating
// gated-cycle counter on sleep_cnt_o; otherwise sleep_cnt_o is tied to 0.
module cv32e40p_cluster_clock_ctrl #(
  parameter int unsigned NUM_EVT    = 8,
  parameter int unsigned WAKE_DELAY = 2   // legal range 1..15
) (
  input  logic                         clk_ungated_i,
  input  logic                         rst_i,
  cv32e40p_cluster_clock_ctrl_if.slave core_if,
  input  logic [NUM_EVT-1:0]           evt_i,
  input  logic [NUM_EVT-1:0]           evt_mask_i,
  input  logic [NUM_EVT-1:0]           evt_clr_i,
  output logic [NUM_EVT-1:0]           evt_pending_o,
  input  logic                         irq_req_i,
  input  logic                         debug_req_i,
  input  logic                         sleep_cnt_clr_i,
  output logic [31:0]                  sleep_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_e;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DELAY - 1);

  state_e             state_q, state_d;
  logic [3:0]         wake_cnt_q, wake_cnt_d;
  logic               clk_en_q, clk_en_d;
  logic [NUM_EVT-1:0] evt_pending_q;
  logic               wake;

  assign wake = (|(evt_pending_q & evt_mask_i)) | irq_req_i | debug_req_i;

  // Pending event register: a new event beats a same-cycle clear.
  always_ff @(posedge clk_ungated_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) evt_pending_q <= '0;
    else       evt_pending_q <= (evt_pending_q & ~evt_clr_i) | evt_i;
  end

  // Next-state logic for the sleep FSM and its wake-up counter.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      RUN: begin
        // A wake source present in the request cycle keeps the core running.
        if (core_if.core_sleep_i && core_if.bus_idle_i && !wake) state_d = GATED;
      end
      GATED: begin
        // A dropped sleep request while gated is treated like a wake.
        if (wake || !core_if.core_sleep_i) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt_q == 4'd0) state_d = RUN;
        else                    wake_cnt_d = wake_cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
    clk_en_d = (state_d != GATED);
  end

  // FSM state, wake counter and registered clock enable.
  always_ff @(posedge clk_ungated_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wake_cnt_q <= 4'd0;
      clk_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= clk_en_d;
    end
  end

  // The clock is never gated while the core is awake, whatever the FSM says.
  assign core_if.pulp_clock_en_o = clk_en_q | ~core_if.core_sleep_i;
  assign core_if.irq_o           = irq_req_i   & (state_q == RUN);
  assign core_if.debug_req_o     = debug_req_i & (state_q == RUN);
  assign core_if.bus_block_o     = (state_q != RUN);
  assign evt_pending_o           = evt_pending_q;

`ifdef CV32E40P_SLEEP_CNT_EN
  logic [31:0] sleep_cnt_q;

  // Saturating count of gated cycles; clear wins over increment.
  always_ff @(posedge clk_ungated_i or posedge rst_i) begin
    if (rst_i)                                            sleep_cnt_q <= '0;
    else if (sleep_cnt_clr_i)                             sleep_cnt_q <= '0;
    else if (state_q == GATED && sleep_cnt_q != '1)       sleep_cnt_q <= sleep_cnt_q + 32'd1;
  end

  assign sleep_cnt_o = sleep_cnt_q;
`else
  logic unused_sleep_cnt_clr;
  assign unused_sleep_cnt_clr = sleep_cnt_clr_i;
  assign sleep_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_cluster_clock_ctrl.sv
// Self-checking bench for cv32e40p_cluster_clock_ctrl: directed scenarios
// followed by randomized traffic, all compared against a timing-rule model.
module tb_cv32e40p_cluster_clock_ctrl;
  localparam int NUM_EVT    = 8;
  localparam int WAKE_DELAY = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_EVT-1:0] evt, evt_mask, evt_clr;
  logic [NUM_EVT-1:0] evt_pending;
  logic               irq_req, debug_req, cnt_clr;
  logic [31:0]        sleep_cnt;

  int checks = 0;
  int errors = 0;

  cv32e40p_cluster_clock_ctrl_if core_if ();

  cv32e40p_cluster_clock_ctrl #(
    .NUM_EVT    (NUM_EVT),
    .WAKE_DELAY (WAKE_DELAY)
  ) dut (
    .clk_ungated_i   (clk),
    .rst_i           (rst),
    .core_if         (core_if),
    .evt_i           (evt),
    .evt_mask_i      (evt_mask),
    .evt_clr_i       (evt_clr),
    .evt_pending_o   (evt_pending),
    .irq_req_i       (irq_req),
    .debug_req_i     (debug_req),
    .sleep_cnt_clr_i (cnt_clr),
    .sleep_cnt_o     (sleep_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: "asleep" means the core clock is off; "wake_left" is
  // the number of cycles still to elapse before traffic is released.
  bit                 m_asleep;
  int                 m_wake_left;
  logic [NUM_EVT-1:0] m_pend;
  longint unsigned    m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_asleep    = 0;
    m_wake_left = 0;
    m_pend      = '0;
    m_cnt       = 0;
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic compare_outputs();
    bit running;
    running = !m_asleep && (m_wake_left == 0);
    check("clock_en",  32'(core_if.pulp_clock_en_o), 32'(!m_asleep || !core_if.core_sleep_i));
    check("irq",       32'(core_if.irq_o),           32'(irq_req && running));
    check("debug",     32'(core_if.debug_req_o),     32'(debug_req && running));
    check("bus_block", 32'(core_if.bus_block_o),     32'(!running));
    check("pending",   32'(evt_pending),             32'(m_pend));
    check("irq_gated", 32'(core_if.irq_o & ~core_if.pulp_clock_en_o), 32'd0);
`ifdef CV32E40P_SLEEP_CNT_EN
    check("sleep_cnt", sleep_cnt, 32'(m_cnt));
`else
    check("sleep_cnt", sleep_cnt, 32'd0);
`endif
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    bit wake, running;
    wake    = (|(m_pend & evt_mask)) || irq_req || debug_req;
    running = !m_asleep && (m_wake_left == 0);
    if (cnt_clr)                                m_cnt = 0;
    else if (m_asleep && m_cnt != 64'hFFFFFFFF) m_cnt = m_cnt + 1;
    if (running) begin
      if (core_if.core_sleep_i && core_if.bus_idle_i && !wake) m_asleep = 1;
    end else if (m_asleep) begin
      if (wake || !core_if.core_sleep_i) begin
        m_asleep    = 0;
        m_wake_left = WAKE_DELAY;
      end
    end else begin
      m_wake_left--;
    end
    m_pend = (m_pend & ~evt_clr) | evt;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle_inputs();
    core_if.core_sleep_i = 1'b0;
    core_if.bus_idle_i   = 1'b1;
    evt       = '0;
    evt_mask  = '0;
    evt_clr   = '0;
    irq_req   = 1'b0;
    debug_req = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset values.
    check("rst_clock_en",  32'(core_if.pulp_clock_en_o), 32'd1);
    check("rst_bus_block", 32'(core_if.bus_block_o),     32'd0);
    check("rst_pending",   32'(evt_pending),             32'd0);
    check("rst_irq",       32'(core_if.irq_o),           32'd0);
    check("rst_sleep_cnt", sleep_cnt,                    32'd0);
    tick();

    // Event wake with mask[3].
    core_if.core_sleep_i = 1'b1;
    evt_mask = 8'h08;
    tick();                                   // sleep entry edge
    #1 check("gated_clock_en", 32'(core_if.pulp_clock_en_o), 32'd0);
    check("gated_bus_block", 32'(core_if.bus_block_o), 32'd1);
    tick();
    evt = 8'h08;
    tick();                                   // cycle m
    evt = '0;
    #1 check("evt_pending_08", 32'(evt_pending), 32'h08);
    check("m1_clock_en", 32'(core_if.pulp_clock_en_o), 32'd0);
    tick();
    #1 check("m2_clock_en", 32'(core_if.pulp_clock_en_o), 32'd1);
    check("m2_bus_block", 32'(core_if.bus_block_o), 32'd1);
    tick();
    tick();
    #1 check("m4_bus_block", 32'(core_if.bus_block_o), 32'd0);

    // Clear pending with mask off; core gates again, then irq held.
    evt_clr  = 8'h08;
    evt_mask = '0;
    tick();
    evt_clr = '0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (10) tick();
`ifdef CV32E40P_SLEEP_CNT_EN
    #1 check("cnt_after_gate", sleep_cnt, 32'(m_cnt));
`endif
    evt = 8'h01;                              // masked-off event: no wake
    tick();
    evt = '0;
    repeat (3) tick();
    #1 check("masked_stays_gated", 32'(core_if.pulp_clock_en_o), 32'd0);
    irq_req = 1'b1;
    repeat (6) tick();
    #1 check("irq_forwarded", 32'(core_if.irq_o), 32'd1);
    irq_req = 1'b0;

    // Same-cycle sleep request and unmasked pending event: stay in RUN.
    evt_mask = 8'h01;
    repeat (3) tick();
    #1 check("pending_blocks_sleep", 32'(core_if.bus_block_o), 32'd0);
    evt_clr  = 8'h01;
    evt_mask = '0;
    tick();
    evt_clr = '0;

    // bus_idle low blocks sleep; debug wake while gated.
    core_if.core_sleep_i = 1'b0;
    repeat (5) tick();
    core_if.core_sleep_i = 1'b1;
    core_if.bus_idle_i   = 1'b0;
    repeat (5) tick();
    #1 check("busy_stays_run", 32'(core_if.bus_block_o), 32'd0);
    core_if.bus_idle_i = 1'b1;
    tick();
    #1 check("idle_then_gated", 32'(core_if.pulp_clock_en_o), 32'd0);
    debug_req = 1'b1;
    repeat (5) tick();
    debug_req = 1'b0;

    // Asynchronous reset while gated.
    repeat (3) tick();
    evt = 8'h40;
    tick();
    evt = '0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_clock_en", 32'(core_if.pulp_clock_en_o), 32'd1);
    check("async_rst_pending",  32'(evt_pending),             32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      core_if.core_sleep_i = ($urandom_range(0, 9) != 0);
      core_if.bus_idle_i   = ($urandom_range(0, 5) != 0);
      evt       = ($urandom_range(0, 7) == 0) ? NUM_EVT'($urandom) : '0;
      evt_mask  = NUM_EVT'($urandom);
      evt_clr   = ($urandom_range(0, 3) == 0) ? NUM_EVT'($urandom) : '0;
      irq_req   = ($urandom_range(0, 15) == 0);
      debug_req = ($urandom_range(0, 31) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
